// File: rtl/p2m_echo_indication_deser_pkg.sv
// Shared definitions for the EchoIndication receive-side deserializer:
// method ids, message length lookup, default portal id and FSM state encoding.
// Imported by the interface-facing top and the word collector.
package p2m_echo_indication_deser_pkg;

  localparam logic [15:0] PORTAL_ID_DEF = 16'd5;

  // Method ids carried in header bits [31:16]
  localparam logic [15:0] HEARD2 = 16'd0;
  localparam logic [15:0] HEARD3 = 16'd1;
  localparam logic [15:0] HEARD  = 16'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPATCH = 2'd2
  } state_t;

  // Total message length in words, header included; 0 marks an unknown id
  function automatic logic [2:0] msg_len(input logic [15:0] id);
    logic [2:0] len;
    len = 3'd0;
    case (id)
      HEARD2:  len = 3'd2;
      HEARD3:  len = 3'd4;
      HEARD:   len = 3'd2;
      default: len = 3'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/p2m_echo_indication_deser_if.sv
// Bundle of the word-stream input and the three indication method ports.
// slave is the deserializer side, master is the transport/consumer side.
// All handshakes are ENA/RDY: ENA is only raised while RDY is high.
interface p2m_echo_indication_deser_if;

    logic        in_enq__ENA;
    logic [31:0] in_enq_v;
    logic        in_enq__RDY;

    logic        method_heard__ENA;
    logic [31:0] method_heard_v;
    logic        method_heard__RDY;

    logic        method_heard2__ENA;
    logic [15:0] method_heard2_a;
    logic [15:0] method_heard2_b;
    logic        method_heard2__RDY;

    logic        method_heard3__ENA;
    logic [15:0] method_heard3_a;
    logic [31:0] method_heard3_b;
    logic [31:0] method_heard3_c;
    logic [15:0] method_heard3_d;
    logic        method_heard3__RDY;

    modport slave (
        input  in_enq__ENA, in_enq_v,
        output in_enq__RDY,
        output method_heard__ENA, method_heard_v,
        input  method_heard__RDY,
        output method_heard2__ENA, method_heard2_a, method_heard2_b,
        input  method_heard2__RDY,
        output method_heard3__ENA, method_heard3_a, method_heard3_b,
        output method_heard3_c, method_heard3_d,
        input  method_heard3__RDY
    );

    modport master (
        output in_enq__ENA, in_enq_v,
        input  in_enq__RDY,
        input  method_heard__ENA, method_heard_v,
        output method_heard__RDY,
        input  method_heard2__ENA, method_heard2_a, method_heard2_b,
        output method_heard2__RDY,
        input  method_heard3__ENA, method_heard3_a, method_heard3_b,
        input  method_heard3_c, method_heard3_d,
        output method_heard3__RDY
    );

endinterface

// File: rtl/p2m_word_collector.sv
// Header check, payload index counter and 3x32 payload register file.
// Words are captured on the accepting edge; last is flagged combinationally.
// No backpressure of its own: the parent only presents accepted words.
module p2m_word_collector
  import p2m_echo_indication_deser_pkg::*;
#(
  parameter logic [15:0] PORTAL_ID = PORTAL_ID_DEF,
  parameter int          ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,     // a word is taken this cycle
  input  logic [31:0]      word,
  input  logic             hdr_phase,  // the next accepted word is a header
  input  logic             clr,        // dispatch handshake done
  output logic             hdr_ok,
  output logic             last,
  output logic [1:0]       mid,
  output logic [31:0]      w1,
  output logic [31:0]      w2,
  output logic [31:0]      w3,
  output logic [ERR_W-1:0] err_count
);

  logic [1:0] idx;
  logic [1:0] need;

  // A header is good when it targets this portal and names a known method
  assign hdr_ok = (word[15:0] == PORTAL_ID) && (msg_len(word[31:16]) != 3'd0);
  assign last   = accept && !hdr_phase && (idx == need);

  // Header latch, payload capture at w[idx], saturating drop counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= 2'd0;
      need      <= 2'd0;
      mid       <= 2'd0;
      w1        <= 32'd0;
      w2        <= 32'd0;
      w3        <= 32'd0;
      err_count <= '0;
    end else if (clr) begin
      idx <= 2'd0;
    end else if (accept) begin
      if (hdr_phase) begin
        if (hdr_ok) begin
          mid  <= word[17:16];
          need <= 2'(msg_len(word[31:16]) - 3'd1);
          idx  <= 2'd1;
        end else if (err_count != '1) begin
          err_count <= err_count + ERR_W'(1);
        end
      end else begin
        case (idx)
          2'd1:    w1 <= word;
          2'd2:    w2 <= word;
          2'd3:    w3 <= word;
          default: ;
        endcase
        idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/p2m_echo_indication_deser.sv
// Reassembles EchoIndication messages from a 32-bit word stream and dispatches one method.
// Latency: last payload word accepted at cycle N, method ENA may assert at N+1.
// Input RDY drops for the whole dispatch phase until the selected consumer is ready.
module p2m_echo_indication_deser
    import p2m_echo_indication_deser_pkg::*;
#(
    parameter logic [15:0] PORTAL_ID = PORTAL_ID_DEF,
    parameter int          ERR_W     = 16
) (
    input  logic                 CLK,
    input  logic                 nRST,
    p2m_echo_indication_deser_if.slave bus,
    output logic [ERR_W-1:0]     err_count
);

    state_t      state;
    logic        accept;
    logic        hdr_ok;
    logic        last;
    logic        fire;
    logic [1:0]  mid;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;

    assign bus.in_enq__RDY = (state != DISPATCH);
    assign accept          = bus.in_enq__ENA && bus.in_enq__RDY;

    // Only the latched method may fire, and only while its consumer is ready
    assign bus.method_heard__ENA  = (state == DISPATCH) && (mid == HEARD[1:0])  && bus.method_heard__RDY;
    assign bus.method_heard2__ENA = (state == DISPATCH) && (mid == HEARD2[1:0]) && bus.method_heard2__RDY;
    assign bus.method_heard3__ENA = (state == DISPATCH) && (mid == HEARD3[1:0]) && bus.method_heard3__RDY;
    assign fire = bus.method_heard__ENA || bus.method_heard2__ENA || bus.method_heard3__ENA;

    // Arguments come straight from the payload registers, which are frozen during dispatch
    assign bus.method_heard_v  = w1;
    assign bus.method_heard2_a = w1[15:0];
    assign bus.method_heard2_b = w1[31:16];
    assign bus.method_heard3_a = w1[15:0];
    assign bus.method_heard3_b = {w2[15:0], w1[31:16]};
    assign bus.method_heard3_c = {w3[15:0], w2[31:16]};
    assign bus.method_heard3_d = w3[31:16];

    p2m_word_collector #(
        .PORTAL_ID (PORTAL_ID),
        .ERR_W     (ERR_W)
    ) u_collector (
        .clk       (CLK),
        .rst_n     (nRST),
        .accept    (accept),
        .word      (bus.in_enq_v),
        .hdr_phase (state == IDLE),
        .clr       (fire),
        .hdr_ok    (hdr_ok),
        .last      (last),
        .mid       (mid),
        .w1        (w1),
        .w2        (w2),
        .w3        (w3),
        .err_count (err_count)
    );

    // Message FSM: wait for a good header, collect payload, hold until dispatched
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:     if (accept && hdr_ok) state <= COLLECT;
                COLLECT:  if (last)             state <= DISPATCH;
                DISPATCH: if (fire)             state <= IDLE;
                default:                        state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p2m_echo_indication_deser.sv
// Scoreboarded bench: directed plan cases followed by random message traffic.
// A reference model turns each sent message into its expected method call;
// a negedge monitor pops and compares whenever any method ENA is seen.
module tb_p2m_echo_indication_deser;

    typedef struct {
        int          m;     // 0 heard2, 1 heard3, 2 heard
        logic [95:0] args;  // arguments packed last-to-first, first argument in the LSBs
    } exp_t;

    logic CLK;
    logic nRST;
    logic [15:0] err_count;

    p2m_echo_indication_deser_if bus();

    p2m_echo_indication_deser #(.PORTAL_ID(16'd5), .ERR_W(16)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus),
        .err_count (err_count)
    );

    exp_t sbq[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_pushed = 0;
    int   n_fired = 0;
    int   model_err = 0;
    bit   rand_rdy = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Reference model: arguments are the payload bitstream {wN..w1} cut into
    // fields in declaration order, so the packed argument vector equals the payload.
    function automatic exp_t model(input int m, input logic [31:0] p1, p2, p3);
        exp_t e;
        e.m = m;
        if (m == 1) e.args = {p3, p2, p1};
        else        e.args = {64'd0, p1};
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the word was taken
    task automatic send_word(input logic [31:0] w);
        int t;
        t = 0;
        while (!bus.in_enq__RDY) begin
            @(posedge CLK); #1;
            t++;
            if (t > 300) begin
                check("enq_rdy_timeout", 96'd0, 96'd1);
                return;
            end
        end
        bus.in_enq__ENA = 1'b1;
        bus.in_enq_v    = w;
        @(posedge CLK); #1;
        bus.in_enq__ENA = 1'b0;
    endtask

    task automatic send_msg(input int m, input logic [31:0] p1, p2, p3);
        logic [31:0] hdr;
        hdr = {16'(m), 16'h0005};
        sbq.push_back(model(m, p1, p2, p3));
        n_pushed++;
        send_word(hdr);
        send_word(p1);
        if (m == 1) begin
            send_word(p2);
            send_word(p3);
        end
    endtask

    task automatic set_rdy(input logic r1, r2, r3);
        bus.method_heard__RDY  = r1;
        bus.method_heard2__RDY = r2;
        bus.method_heard3__RDY = r3;
    endtask

    // Randomized consumer readiness, updated off the sampling edge
    initial begin
        forever begin
            @(posedge CLK); #1;
            if (rand_rdy) begin
                bus.method_heard__RDY  = ($urandom_range(0, 3) != 0);
                bus.method_heard2__RDY = ($urandom_range(0, 3) != 0);
                bus.method_heard3__RDY = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: every ENA observed is one dispatched call to match against the scoreboard
    always @(negedge CLK) begin
        int   n;
        exp_t e;
        exp_t a;
        if (nRST) begin
            n = int'(bus.method_heard__ENA) + int'(bus.method_heard2__ENA) + int'(bus.method_heard3__ENA);
            if (n != 0) begin
                n_fired++;
                check("one_ena", 96'(n), 96'd1);
                check("enq_rdy_in_dispatch", {95'd0, bus.in_enq__RDY}, 96'd0);
                a.m = 0;
                a.args = 96'd0;
                if (bus.method_heard__ENA) begin
                    a.m = 2; a.args = {64'd0, bus.method_heard_v};
                end else if (bus.method_heard2__ENA) begin
                    a.m = 0; a.args = {64'd0, bus.method_heard2_b, bus.method_heard2_a};
                end else begin
                    a.m = 1; a.args = {bus.method_heard3_d, bus.method_heard3_c, bus.method_heard3_b, bus.method_heard3_a};
                end
                if (sbq.size() == 0) begin
                    check("unexpected_ena", 96'd1, 96'd0);
                end else begin
                    e = sbq.pop_front();
                    check("method_id", 96'(a.m), 96'(e.m));
                    check("method_args", a.args, e.args);
                end
            end
        end
    end

    initial begin
        logic [31:0] p1, p2, p3, bad;
        int m, t;

        bus.in_enq__ENA = 1'b0;
        bus.in_enq_v    = 32'd0;
        set_rdy(1'b1, 1'b1, 1'b1);
        nRST = 1'b0;
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;

        // Reset state
        check("rst_err_count", 96'(err_count), 96'd0);
        check("rst_enq_rdy", {95'd0, bus.in_enq__RDY}, 96'd1);
        check("rst_enas", {93'd0, bus.method_heard__ENA, bus.method_heard2__ENA, bus.method_heard3__ENA}, 96'd0);

        // heard: ENA one cycle after the last word, single pulse
        send_msg(2, 32'hDEADBEEF, 32'd0, 32'd0);
        check("heard_ena_latency", {95'd0, bus.method_heard__ENA}, 96'd1);
        check("heard_others_low", {94'd0, bus.method_heard2__ENA, bus.method_heard3__ENA}, 96'd0);
        check("heard_v", 96'(bus.method_heard_v), 96'hDEADBEEF);
        @(posedge CLK); #1;
        check("heard_single_pulse", {95'd0, bus.method_heard__ENA}, 96'd0);

        // heard2
        send_msg(0, 32'h22221111, 32'd0, 32'd0);
        check("heard2_ena", {95'd0, bus.method_heard2__ENA}, 96'd1);
        check("heard2_ab", {64'd0, bus.method_heard2_b, bus.method_heard2_a}, {64'd0, 16'h2222, 16'h1111});
        @(posedge CLK); #1;

        // heard3 with the consumer stalled for 5 cycles
        set_rdy(1'b1, 1'b1, 1'b0);
        send_msg(1, 32'h5678AAAA, 32'hDEF01234, 32'h55559ABC);
        for (int i = 0; i < 5; i++) begin
            check("bp_enq_rdy_low", {95'd0, bus.in_enq__RDY}, 96'd0);
            check("bp_ena_low", {95'd0, bus.method_heard3__ENA}, 96'd0);
            check("bp_args_stable",
                  {bus.method_heard3_d, bus.method_heard3_c, bus.method_heard3_b, bus.method_heard3_a},
                  {16'h5555, 32'h9ABCDEF0, 32'h12345678, 16'hAAAA});
            @(posedge CLK); #1;
        end
        set_rdy(1'b1, 1'b1, 1'b1);
        #1;
        check("bp_ena_on_rdy", {95'd0, bus.method_heard3__ENA}, 96'd1);
        @(posedge CLK); #1;
        check("bp_next_hdr_ready", {95'd0, bus.in_enq__RDY}, 96'd1);
        send_msg(2, 32'h0BADF00D, 32'd0, 32'd0);
        @(posedge CLK); #1;

        // Bad headers are dropped and counted
        send_word(32'h00020006);
        send_word(32'h00070005);
        model_err += 2;
        check("bad_hdr_err_count", 96'(err_count), 96'(model_err));
        check("bad_hdr_no_ena", {93'd0, bus.method_heard__ENA, bus.method_heard2__ENA, bus.method_heard3__ENA}, 96'd0);
        check("bad_hdr_still_idle", {95'd0, bus.in_enq__RDY}, 96'd1);
        send_msg(2, 32'hCAFE0001, 32'd0, 32'd0);
        @(posedge CLK); #1;

        // Reset in the middle of a heard3 message discards it
        send_word(32'h00010005);
        send_word(32'h5678AAAA);
        nRST = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        model_err = 0;
        check("midrst_err_count", 96'(err_count), 96'd0);
        check("midrst_enq_rdy", {95'd0, bus.in_enq__RDY}, 96'd1);
        send_msg(2, 32'h13572468, 32'd0, 32'd0);
        @(posedge CLK); #1;

        // Random traffic: mixed methods, header-lookalike payloads, bad headers, random readiness
        rand_rdy = 1;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                bad = $urandom;
                if (bad[15:0] == 16'd5 && bad[31:16] < 16'd3) bad[15:0] = 16'd6;
                send_word(bad);
                model_err++;
            end
            m  = $urandom_range(0, 2);
            p1 = $urandom;
            p2 = $urandom;
            p3 = $urandom;
            if ($urandom_range(0, 3) == 0) p1 = 32'h00020005;
            if ($urandom_range(0, 3) == 0) p2 = 32'h00010005;
            send_msg(m, p1, p2, p3);
        end

        // Drain: let every collected message dispatch
        set_rdy(1'b1, 1'b1, 1'b1);
        rand_rdy = 0;
        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(posedge CLK); #1;
            t++;
        end
        repeat (2) @(posedge CLK);
        #1;
        check("drain_queue_empty", 96'(sbq.size()), 96'd0);
        check("fired_vs_sent", 96'(n_fired), 96'(n_pushed));
        check("final_err_count", 96'(err_count), 96'(model_err));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/p2m_echo_indication_deser.md
Name: p2m_echo_indication_deser

Overview:
- Receive-side counterpart of the EchoIndication method-to-pipe serializer.
- Consumes a 32-bit word stream from the portal transport and reassembles each message (header plus payload words).
- Validates the header, then dispatches exactly one indication method call (heard, heard2 or heard3) with its unpacked arguments, using ENA/RDY handshakes on both sides.
- Sits between the transport FIFO and the software-facing or loopback indication consumer.

Parameters:
PORTAL_ID, 16'd5, required value of header bits [15:0]
ERR_W, 16, width of the saturating error counter

Ports:
CLK  input  1  clock
nRST  input  1  synchronous active-low reset
in$enq__ENA  input  1  word valid; asserted only when in$enq__RDY=1
in$enq$v  input  32  stream word
in$enq__RDY  output  1  block can accept a word
method$heard__ENA  output  1  dispatch heard
method$heard$v  output  32  heard argument v
method$heard__RDY  input  1  consumer ready for heard
method$heard2__ENA  output  1  dispatch heard2
method$heard2$a  output  16  heard2 argument a
method$heard2$b  output  16  heard2 argument b
method$heard2__RDY  input  1  consumer ready for heard2
method$heard3__ENA  output  1  dispatch heard3
method$heard3$a  output  16  heard3 argument a
method$heard3$b  output  32  heard3 argument b
method$heard3$c  output  32  heard3 argument c
method$heard3$d  output  16  heard3 argument d
method$heard3__RDY  input  1  consumer ready for heard3
err_count  output  ERR_W  count of dropped header words, saturating

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-low on nRST and is sampled only at the CLK edge.
- Reset state: state=IDLE, word index=0, payload registers=0, err_count=0, all __ENA outputs=0.
- Header word format: [15:0]=portal id, [31:16]=method id.
- Method ids and total message lengths (header included):
  - heard2: id 0, 2 words
  - heard3: id 1, 4 words
  - heard: id 2, 2 words
- Payload word numbering: w1..w3 follow the header in order.
- States:
  - IDLE: in$enq__RDY=1. On an accepted word, check the header.
    - portal id == PORTAL_ID and method id in {0,1,2}: latch the method id, set need = length-1, go to COLLECT.
    - otherwise: drop the word, increment err_count (saturate at all-ones), stay in IDLE.
  - COLLECT: in$enq__RDY=1. Each accepted word is stored at w[index] and index increments. When the last word is accepted, go to DISPATCH on the next cycle.
  - DISPATCH: in$enq__RDY=0. Only the selected method's ENA = its RDY; the other two ENAs are 0. When the handshake fires, clear index and go to IDLE. The state is held indefinitely while RDY=0.
- Argument outputs are driven from registers and stay stable throughout DISPATCH. Outside DISPATCH their values are don't-care but deterministic (the last latched values).
- Argument unpacking:
  - heard: v = w1
  - heard2: a = w1[15:0], b = w1[31:16]
  - heard3: a = w1[15:0], b = {w2[15:0], w1[31:16]}, c = {w3[15:0], w2[31:16]}, d = w3[31:16]
- Latency: last word accepted at cycle N → ENA can assert at N+1. A new header can be accepted no earlier than the cycle after the dispatch handshake.
- A payload word is never validated as a header, even when it looks like one.
- No outstanding message is preserved across reset. Reset during COLLECT or DISPATCH discards the partial message and produces no ENA pulse.
- At most one method ENA is high in any cycle.

Decomposition:
- Shared package:
  - method id constants: HEARD2=0, HEARD3=1, HEARD=2
  - a length lookup function: id → word count
  - the PORTAL_ID default
  - the state enum: IDLE, COLLECT, DISPATCH
- One natural sub-module, p2m_word_collector: header check, index counter and 3×32-bit payload register file. The top level holds the dispatch FSM and argument unpacking.

Test Plan:
- heard: stream 0x00020005, 0xDEADBEEF, heard__RDY=1 → method$heard__ENA pulses once, 1 cycle after word 2, with v=0xDEADBEEF; the other ENAs stay 0.
- heard2: stream 0x00000005, 0x22221111 → heard2__ENA with a=0x1111, b=0x2222.
- heard3: stream 0x00010005, 0x5678AAAA, 0xDEF01234, 0x55559ABC → heard3__ENA with a=0xAAAA, b=0x12345678, c=0x9ABCDEF0, d=0x5555.
- Backpressure: heard3__RDY held 0 for 5 cycles after collection → in$enq__RDY=0 and arguments stable throughout; ENA fires on the first cycle RDY=1; the next header is accepted the following cycle.
- Bad headers: words 0x00020006 (wrong portal) then 0x00070005 (bad id) → both dropped, err_count=2, no ENA. A valid heard message that follows dispatches normally.
- Reset mid-message: stream 0x00010005, 0x5678AAAA, drop nRST for 1 cycle, then a full heard message → only heard__ENA fires; err_count=0.
